// File: rtl/waveform_capture.sv
// ---------------------------------------------------------------------------
// waveform_capture
//
// Sample-capture front end for the OLED waveform plotter. Samples the eight
// synchronized input channels at a programmable rate, optionally waits for an
// edge on one selected channel, stores DEPTH samples in a register buffer and
// then streams them one byte at a time over a valid/ready handshake.
//
// Ports
//   clk          clock
//   rst_n        synchronous active-low reset
//   sample_in    channel inputs (bit 7 = channel 7), already synchronized
//   address      peripheral register address
//   data_write   one-cycle register write strobe
//   data_in      register write data
//   data_out     register read data, combinational on address
//   smp_valid    sample byte available to the plotter (registered)
//   smp_data     sample byte (registered)
//   smp_ready    plotter accepts the current sample
//   busy         high whenever the capture engine is not idle
//
// Register map
//   0  W: [0] arm, [1] abort (both self-clearing), [4:2] trigger channel,
//         [5] polarity (1 = rising), [6] trigger enable, [7] auto-stream
//      R: {busy, 4'b0, state}
//   1  RW: sample-rate divider; writes accepted only while idle
//   2  W: stream command (any data)   R: number of samples stored
// ---------------------------------------------------------------------------
module waveform_capture #(
   parameter int DEPTH = 16,
   parameter int DIV_W = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] sample_in,
   input  logic [3:0] address,
   input  logic       data_write,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       smp_valid,
   output logic [7:0] smp_data,
   input  logic       smp_ready,
   output logic       busy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_TRIG = 3'd1,
      CAPTURE   = 3'd2,
      FULL      = 3'd3,
      STREAM    = 3'd4
   } state_t;

   state_t             r_state;
   logic [DIV_W-1:0]   r_div;
   logic [DIV_W-1:0]   r_div_cnt;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic               r_full;      // count MSB: wr_ptr has wrapped after DEPTH samples
   logic [7:0]         r_prev;      // sample seen at the previous trigger-search tick
   logic [2:0]         r_trig_ch;
   logic               r_trig_pol;
   logic               r_trig_en;
   logic               r_auto;
   logic               r_smp_valid;
   logic [7:0]         r_smp_data;
   logic [7:0]         r_mem [DEPTH];

   logic               w_ctrl_wr;
   logic               w_abort;
   logic               w_arm;
   logic               w_div_wr;
   logic               w_stream_cmd;
   logic               w_tick;
   logic               w_ch_now;
   logic               w_ch_prev;
   logic               w_trig;
   logic               w_mem_we;
   logic [PTR_W-1:0]   w_mem_idx;
   logic [PTR_W:0]     w_count;

   // Register interface decode. Abort takes priority over a simultaneous arm.
   assign w_ctrl_wr    = data_write && (address == 4'd0);
   assign w_abort      = w_ctrl_wr && data_in[1];
   assign w_arm        = w_ctrl_wr && data_in[0] && !data_in[1];
   assign w_div_wr     = data_write && (address == 4'd1);
   assign w_stream_cmd = data_write && (address == 4'd2);

   // The divider counter reloads on every tick, giving a period of DIV+1.
   assign w_tick = (r_div_cnt == '0);

   assign w_ch_now  = sample_in[r_trig_ch];
   assign w_ch_prev = r_prev[r_trig_ch];
   assign w_trig    = r_trig_en &&
                      (r_trig_pol ? (!w_ch_prev && w_ch_now) : (w_ch_prev && !w_ch_now));

   // The triggering sample always lands in slot 0; plain capture uses wr_ptr.
   assign w_mem_we  = rst_n && !w_abort && w_tick &&
                      (((r_state == WAIT_TRIG) && w_trig) || (r_state == CAPTURE));
   assign w_mem_idx = (r_state == WAIT_TRIG) ? '0 : r_wr_ptr;

   assign w_count = {r_full, r_wr_ptr};

   assign busy      = (r_state != IDLE);
   assign smp_valid = r_smp_valid;
   assign smp_data  = r_smp_data;

   // NOTE: every variable assigned in a combinational block gets a default
   // first, so no path through the case leaves it unassigned (no latch).
   always_comb begin
      data_out = '0;
      case (address)
         4'd0:    data_out = {busy, 4'b0000, r_state};
         4'd1:    data_out = 8'(r_div);
         4'd2:    data_out = 8'(w_count);
         default: data_out = '0;
      endcase
   end

   // NOTE: the sample buffer is deliberately left out of reset; it is only
   // read after being fully rewritten by a capture, and a reset-free array
   // maps onto plain storage without a clear path.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_idx] <= sample_in;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // right-hand side below sees the values from before this clock edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_div       <= '0;
         r_div_cnt   <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_full      <= 1'b0;
         r_prev      <= '0;
         r_trig_ch   <= '0;
         r_trig_pol  <= 1'b0;
         r_trig_en   <= 1'b0;
         r_auto      <= 1'b0;
         r_smp_valid <= 1'b0;
         r_smp_data  <= '0;
      end else begin
         // Configuration is frozen while a capture or stream is in progress.
         if ((r_state == IDLE) && w_ctrl_wr) begin
            r_trig_ch  <= data_in[4:2];
            r_trig_pol <= data_in[5];
            r_trig_en  <= data_in[6];
            r_auto     <= data_in[7];
         end
         if ((r_state == IDLE) && w_div_wr) begin
            r_div <= DIV_W'(data_in);
         end

         if (w_abort) begin
            r_state     <= IDLE;
            r_smp_valid <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_arm) begin
                     r_wr_ptr  <= '0;
                     r_full    <= 1'b0;
                     r_div_cnt <= r_div;
                     r_prev    <= sample_in;
                     r_state   <= data_in[6] ? WAIT_TRIG : CAPTURE;
                  end
               end

               WAIT_TRIG: begin
                  if (w_tick) begin
                     r_div_cnt <= r_div;
                     if (w_trig) begin
                        r_wr_ptr <= PTR_W'(1);
                        r_state  <= CAPTURE;
                     end else begin
                        r_prev <= sample_in;
                     end
                  end else begin
                     r_div_cnt <= r_div_cnt - DIV_W'(1);
                  end
               end

               CAPTURE: begin
                  if (w_tick) begin
                     r_div_cnt <= r_div;
                     r_wr_ptr  <= r_wr_ptr + PTR_W'(1);
                     if (r_wr_ptr == LAST_IDX) begin
                        r_full <= 1'b1;
                        if (r_auto) begin
                           r_state     <= STREAM;
                           r_rd_ptr    <= '0;
                           r_smp_valid <= 1'b1;
                           r_smp_data  <= r_mem[0];
                        end else begin
                           r_state <= FULL;
                        end
                     end
                  end else begin
                     r_div_cnt <= r_div_cnt - DIV_W'(1);
                  end
               end

               FULL: begin
                  if (w_stream_cmd) begin
                     r_state     <= STREAM;
                     r_rd_ptr    <= '0;
                     r_smp_valid <= 1'b1;
                     r_smp_data  <= r_mem[0];
                  end
               end

               STREAM: begin
                  // smp_valid is high throughout STREAM, so ready alone
                  // completes a handshake; otherwise the byte is held.
                  if (smp_ready) begin
                     if (r_rd_ptr == LAST_IDX) begin
                        r_state     <= IDLE;
                        r_smp_valid <= 1'b0;
                     end else begin
                        r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
                        r_smp_data <= r_mem[r_rd_ptr + PTR_W'(1)];
                     end
                  end
               end

               default: begin
                  r_state     <= IDLE;
                  r_smp_valid <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_waveform_capture.sv
// ---------------------------------------------------------------------------
// tb_waveform_capture
//
// Self-checking bench for waveform_capture. A register-level vector table
// covers reset values and control decode; hand-written sequences cover the
// multi-cycle cases; a randomized loop exercises divider, trigger and
// handshake pacing. Expected stream contents come from a log of every
// sample_in value the DUT saw, selected by the capture timing rules.
// ---------------------------------------------------------------------------
module tb_waveform_capture;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] sample_in;
   logic [3:0] address;
   logic       data_write;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       smp_valid;
   logic [7:0] smp_data;
   logic       smp_ready;
   logic       busy;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] hist[$];   // sample_in as seen at each clock edge
   logic [7:0] got[$];    // bytes delivered by completed handshakes
   logic [7:0] exp_q[$];  // expected stream for the current capture

   int         samp_mode = 2;   // 0 count up, 1 random, 2 hold hold_val
   logic [7:0] hold_val  = 8'h00;
   int         rdy_mode  = 0;   // 0 high, 1 random, 2 pattern 1-0-0, 3 low
   int         rcyc      = 0;
   bit         valid_seen = 1'b0;

   logic       p_v   = 1'b0;
   logic       p_r   = 1'b0;
   logic       p_rst = 1'b0;
   logic [7:0] p_d   = 8'h00;

   waveform_capture #(.DEPTH(DEPTH), .DIV_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sample_in  (sample_in),
      .address    (address),
      .data_write (data_write),
      .data_in    (data_in),
      .data_out   (data_out),
      .smp_valid  (smp_valid),
      .smp_data   (smp_data),
      .smp_ready  (smp_ready),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Input drivers: change just after the active edge.
   always @(posedge clk) begin
      #1;
      case (samp_mode)
         0:       sample_in = sample_in + 8'd1;
         1:       sample_in = 8'($urandom);
         default: sample_in = hold_val;
      endcase
      rcyc++;
      case (rdy_mode)
         0:       smp_ready = 1'b1;
         1:       smp_ready = 1'($urandom_range(0, 1));
         2:       smp_ready = ((rcyc % 3) == 0);
         default: smp_ready = 1'b0;
      endcase
   end

   // Monitor on the falling edge: values here are those the next edge sees.
   always @(negedge clk) begin
      hist.push_back(sample_in);
      if (rst_n && smp_valid && smp_ready) got.push_back(smp_data);
      if (smp_valid) valid_seen = 1'b1;
      if (p_rst && p_v && !p_r && smp_valid) check("hold_stable", smp_data, p_d);
      p_v   = smp_valid;
      p_r   = smp_ready;
      p_d   = smp_data;
      p_rst = rst_n;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      address    = a;
      data_in    = d;
      data_write = 1'b1;
      tick();
      data_write = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, output logic [7:0] v);
      address = a;
      #1;
      v = data_out;
   endtask

   task automatic wait_state(input logic [2:0] st, input int budget, output int n);
      logic [7:0] v;
      n = 0;
      forever begin
         rd(4'd0, v);
         if (v[2:0] == st) break;
         if (n >= budget) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_state: state %0d after %0d cycles, required %0d", v[2:0], n, st);
            break;
         end
         tick();
         n++;
      end
   endtask

   // Reference: first sample one period after arm (or at the triggering
   // tick), then one sample every DIV+1 edges.
   task automatic build_expect(input int arm_idx, input int div, input bit trig,
                               input int ch, input bit pol, output bit ok);
      int         step;
      int         t;
      logic [7:0] prev;
      logic [7:0] cur;
      step = div + 1;
      t    = arm_idx + step;
      prev = hist[arm_idx];
      ok   = 1'b1;
      exp_q.delete();
      if (trig) begin
         ok = 1'b0;
         while (t < hist.size()) begin
            cur = hist[t];
            if (pol ? (!prev[ch] && cur[ch]) : (prev[ch] && !cur[ch])) begin
               ok = 1'b1;
               break;
            end
            prev = cur;
            t += step;
         end
      end
      if (ok) begin
         for (int k = 0; k < DEPTH; k++) begin
            if (t + k * step < hist.size()) exp_q.push_back(hist[t + k * step]);
         end
      end
   endtask

   task automatic compare_stream(input string name, input bit ok);
      check({name, "_len"}, got.size(), DEPTH);
      if (!ok || exp_q.size() != DEPTH) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_model: DUT completed a capture the rules do not produce (got %0d bytes)",
                  name, got.size());
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("%s[%0d]", name, i), (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
         end
      end
   endtask

   typedef struct {
      logic       do_wr;
      logic [3:0] wa;
      logic [7:0] wd;
      logic [3:0] ra;
      logic [7:0] exp;
      string      name;
   } vec_t;

   initial begin
      vec_t       tbl[15];
      logic [7:0] r;
      int         n;
      int         arm_idx;
      bit         ok;

      tbl[0]  = '{1'b0, 4'd0, 8'h00, 4'd0, 8'h00, "rst_status"};
      tbl[1]  = '{1'b0, 4'd0, 8'h00, 4'd1, 8'h00, "rst_div"};
      tbl[2]  = '{1'b0, 4'd0, 8'h00, 4'd2, 8'h00, "rst_count"};
      tbl[3]  = '{1'b1, 4'd1, 8'h5A, 4'd1, 8'h5A, "div_wr"};
      tbl[4]  = '{1'b1, 4'd7, 8'hFF, 4'd7, 8'h00, "unmapped_rd"};
      tbl[5]  = '{1'b1, 4'd1, 8'h00, 4'd1, 8'h00, "div_clr"};
      tbl[6]  = '{1'b1, 4'd2, 8'h00, 4'd0, 8'h00, "stream_in_idle"};
      tbl[7]  = '{1'b1, 4'd0, 8'h03, 4'd0, 8'h00, "abort_beats_arm"};
      tbl[8]  = '{1'b1, 4'd0, 8'h69, 4'd0, 8'h81, "arm_trig_wait"};
      tbl[9]  = '{1'b1, 4'd1, 8'h09, 4'd1, 8'h00, "div_locked_busy"};
      tbl[10] = '{1'b1, 4'd0, 8'h01, 4'd0, 8'h81, "arm_while_busy"};
      tbl[11] = '{1'b0, 4'd0, 8'h00, 4'd2, 8'h00, "count_waiting"};
      tbl[12] = '{1'b1, 4'd0, 8'h02, 4'd0, 8'h00, "abort_wait"};
      tbl[13] = '{1'b1, 4'd0, 8'h01, 4'd0, 8'h82, "arm_no_trig"};
      tbl[14] = '{1'b1, 4'd0, 8'h02, 4'd0, 8'h00, "abort_capture"};

      rst_n      = 1'b0;
      sample_in  = 8'h00;
      smp_ready  = 1'b1;
      address    = 4'd0;
      data_write = 1'b0;
      data_in    = 8'h00;
      repeat (3) tick();
      rst_n = 1'b1;

      // Register-level vectors (sample_in held at 0, so no trigger fires).
      for (int i = 0; i < 15; i++) begin
         if (tbl[i].do_wr) wr(tbl[i].wa, tbl[i].wd);
         else tick();
         rd(tbl[i].ra, r);
         check(tbl[i].name, r, tbl[i].exp);
      end

      // A: DIV=0, no trigger, counting input, stream with ready high.
      samp_mode = 0;
      rdy_mode  = 0;
      wr(4'd1, 8'd0);
      arm_idx = hist.size();
      got.delete();
      wr(4'd0, 8'h01);
      wait_state(3'd3, 200, n);
      rd(4'd2, r);
      check("count_full", r, 8'd16);
      rd(4'd0, r);
      check("status_full", r, 8'h83);
      build_expect(arm_idx, 0, 1'b0, 0, 1'b0, ok);
      wr(4'd2, 8'h00);
      wait_state(3'd0, 200, n);
      compare_stream("seqA", ok);
      check("valid_low_after_stream", smp_valid, 1'b0);

      // B: DIV=3, FULL exactly 64 edges after arm.
      wr(4'd1, 8'd3);
      arm_idx = hist.size();
      got.delete();
      wr(4'd0, 8'h01);
      wait_state(3'd3, 200, n);
      check("full_latency_div3", n, 64);
      build_expect(arm_idx, 3, 1'b0, 0, 1'b0, ok);
      wr(4'd2, 8'h00);
      wait_state(3'd0, 200, n);
      compare_stream("seqB", ok);
      if (got.size() >= 2) check("div3_stride", 8'(got[1] - got[0]), 8'd4);

      // C: rising trigger on channel 2; a falling edge first must not fire.
      wr(4'd1, 8'd0);
      samp_mode = 2;
      hold_val  = 8'h04;
      repeat (3) tick();
      arm_idx = hist.size();
      got.delete();
      wr(4'd0, 8'h69);
      hold_val = 8'h00;
      repeat (4) tick();
      rd(4'd0, r);
      check("trig_falling_ignored", r, 8'h81);
      repeat (10) tick();
      hold_val = 8'h04;
      wait_state(3'd2, 50, n);
      samp_mode = 0;
      wait_state(3'd3, 200, n);
      build_expect(arm_idx, 0, 1'b1, 2, 1'b1, ok);
      wr(4'd2, 8'h00);
      wait_state(3'd0, 200, n);
      compare_stream("seqC", ok);
      check("trig_first_sample", (got.size() > 0) ? got[0] : 8'hxx, 8'h04);

      // D: auto-stream with ready pattern 1-0-0.
      rdy_mode = 2;
      arm_idx  = hist.size();
      got.delete();
      wr(4'd0, 8'h81);
      wait_state(3'd4, 100, n);
      wait_state(3'd0, 300, n);
      build_expect(arm_idx, 0, 1'b0, 0, 1'b0, ok);
      compare_stream("seqD", ok);
      rd(4'd0, r);
      check("auto_idle_status", r, 8'h00);
      check("auto_busy_low", busy, 1'b0);

      // E: abort during CAPTURE at wr_ptr=5, then re-arm.
      rdy_mode   = 0;
      valid_seen = 1'b0;
      wr(4'd0, 8'h01);
      n = 0;
      forever begin
         rd(4'd2, r);
         if (r == 8'd5 || n > 50) break;
         tick();
         n++;
      end
      check("abort_at_ptr5", r, 8'd5);
      wr(4'd0, 8'h02);
      rd(4'd0, r);
      check("abort_idle", r, 8'h00);
      repeat (5) tick();
      check("abort_no_valid", valid_seen, 1'b0);
      arm_idx = hist.size();
      got.delete();
      wr(4'd0, 8'h01);
      rd(4'd2, r);
      check("rearm_count_zero", r, 8'd0);
      wait_state(3'd3, 200, n);
      build_expect(arm_idx, 0, 1'b0, 0, 1'b0, ok);
      wr(4'd2, 8'h00);
      wait_state(3'd0, 200, n);
      compare_stream("seqE", ok);

      // F: reset pulse mid-STREAM.
      wr(4'd1, 8'd2);
      wr(4'd0, 8'h01);
      wait_state(3'd3, 200, n);
      rdy_mode = 3;
      got.delete();
      wr(4'd2, 8'h00);
      repeat (3) tick();
      rd(4'd0, r);
      check("stream_status", r, 8'h84);
      check("stream_valid", smp_valid, 1'b1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("rst_valid_low", smp_valid, 1'b0);
      rd(4'd0, r);
      check("rst_status_idle", r, 8'h00);
      rd(4'd1, r);
      check("rst_div_zero", r, 8'h00);
      rd(4'd2, r);
      check("rst_count_zero", r, 8'h00);
      check("rst_no_handshake", got.size(), 0);

      // G: randomized captures against the reference.
      samp_mode = 1;
      rdy_mode  = 1;
      for (int it = 0; it < 8; it++) begin
         int         div;
         bit         trig;
         bit         pol;
         bit         aut;
         int         ch;
         logic [7:0] cw;
         bit         done;
         div  = $urandom_range(0, 3);
         trig = 1'($urandom_range(0, 1));
         pol  = 1'($urandom_range(0, 1));
         aut  = 1'($urandom_range(0, 1));
         ch   = $urandom_range(0, 7);
         cw   = {aut, trig, pol, 3'(ch), 2'b01};
         wr(4'd1, 8'(div));
         arm_idx = hist.size();
         got.delete();
         wr(4'd0, cw);
         done = 1'b0;
         for (int c = 0; c < 3000; c++) begin
            rd(4'd0, r);
            if (r[2:0] == 3'd0) begin
               done = 1'b1;
               break;
            end
            if (r[2:0] == 3'd3) wr(4'd2, 8'h00);
            else tick();
         end
         if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL rand%0d_timeout: state %0d, required 0 within 3000 cycles", it, r[2:0]);
            wr(4'd0, 8'h02);
         end
         build_expect(arm_idx, div, trig, ch, pol, ok);
         compare_stream($sformatf("rand%0d", it), ok);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/waveform_capture.md
Name: waveform_capture

Overview:
Sample-capture front end for the OLED waveform plotter. It samples the 8 synchronized input channels at a programmable rate, with an optional edge trigger on one channel, and stores DEPTH samples in a register buffer. It then streams the samples one byte at a time over a valid/ready handshake to the plotter's pixel-column input. Firmware configures and controls it through the TinyQV peripheral register interface.

Parameters:
DEPTH, 16, number of stored samples; power of two, minimum 2.
DIV_W, 8, width of the sample-rate divider register.

Ports:
clk  input  1  clock
rst_n  input  1  reset (synchronous, active-low)
sample_in  input  8  channel inputs, already synchronized (ui_in)
address  input  4  register address
data_write  input  1  register write strobe, one cycle
data_in  input  8  write data
data_out  output  8  read data, combinational on address
smp_valid  output  1  sample available to the plotter
smp_data  output  8  sample byte; bit7 = channel 7
smp_ready  input  1  plotter accepts the sample
busy  output  1  high when state != IDLE

Behaviour:
- Reset is synchronous, active-low, clock clk. Reset values: state IDLE; smp_valid 0; smp_data 0; busy 0; DIV 0; CTRL 0; wr_ptr, rd_ptr, div_cnt 0. Buffer contents are not reset.
- Registers, written when data_write=1:
  - addr 0 CTRL: [0] arm, self-clearing; [1] abort, self-clearing; [4:2] trigger channel; [5] polarity (1 = rising, 0 = falling); [6] trigger enable; [7] auto-stream. Bits [7:2] are stored.
  - addr 1 DIV: written only in IDLE, otherwise ignored.
  - addr 2: any write issues a stream command.
- Reads: addr 0 = {busy, 4'b0, state[2:0]}; addr 1 = DIV; addr 2 = samples stored (wr_ptr, saturating at DEPTH); other addresses = 0.
- State encoding: IDLE=0, WAIT_TRIG=1, CAPTURE=2, FULL=3, STREAM=4.
- Sample tick: in WAIT_TRIG and CAPTURE, tick = (div_cnt==0). On tick, div_cnt <= DIV; otherwise div_cnt decrements. Effective sample period is DIV+1 cycles.
- IDLE: an arm write stores CTRL[7:2], sets wr_ptr=0, div_cnt=DIV and prev=sample_in. Next state is WAIT_TRIG if trigger enable is set, else CAPTURE. State is visible the cycle after the write.
- WAIT_TRIG: on tick, the trigger condition is prev[ch]=0 and sample_in[ch]=1 for rising, or the inverse for falling. On trigger: mem[0]=sample_in, wr_ptr=1, go to CAPTURE. On tick without trigger: prev=sample_in.
- CAPTURE: on tick, mem[wr_ptr]=sample_in and wr_ptr increments. Writing index DEPTH-1 goes to STREAM if auto-stream is set, else FULL. With DIV=0 the first sample is sample_in during the first CAPTURE cycle.
- FULL: a stream command moves to STREAM with rd_ptr=0. Stream commands in any other state are ignored.
- STREAM: smp_valid=1 in every STREAM cycle and smp_data=mem[rd_ptr], both registered outputs.
  - While valid and !ready, smp_data holds stable.
  - On a valid&ready handshake, rd_ptr increments.
  - The handshake at rd_ptr=DEPTH-1 returns to IDLE, with smp_valid=0 on the next cycle.
  - Exactly DEPTH handshakes per capture, in capture order.
- Abort: from any state, the next state is IDLE and smp_valid drops the next cycle. If one write sets both abort and arm, abort wins and the block stays IDLE.
- Arm write while busy: ignored.
- Reset mid-operation: returns to the reset values within one cycle, with no spurious handshake.
- Pointers are $clog2(DEPTH) bits. The stored count is held in a separate bit so FULL reads back DEPTH.

Test Plan:
- DIV=0, trigger off, sample_in counts 0x00,0x01,… per cycle; arm, then stream with smp_ready=1 → 16 handshakes carrying 16 consecutive values starting at the value seen in the first CAPTURE cycle; addr2 reads 16 in FULL.
- DIV=3, sample_in incremented every cycle → stored values differ by 4; FULL reached 64 cycles after arm.
- Trigger enabled, ch=2, rising, sample_in=0x00 then 0x04 after 10 cycles → mem[0]=0x04; stays in WAIT_TRIG (read addr0=0x81) before the edge; a falling edge with polarity=1 does not trigger.
- Auto-stream, smp_ready toggled 1-0-0-1… → smp_data stable while ready low; order preserved; IDLE after the 16th handshake, busy=0.
- Abort write during CAPTURE at wr_ptr=5 → IDLE next cycle, smp_valid never asserted; a subsequent arm restarts at wr_ptr=0.
- rst_n low for one cycle mid-STREAM → smp_valid=0, state IDLE, DIV=0 on the following cycle.
